rtos_delay_list: RTL

- Hardware delayed-task list for the RTOS IP, parametrised in task count, ID width and tick width.
- Holds up to MAX_TASKS (task ID, absolute wake tick) entries, kept sorted by remaining time relative to the live tick.
- Releases expired tasks one per handshake in wake order, supports cancel-by-ID, and handles tick-counter wrap-around.
- Sits beside the ready-list manager: the scheduler inserts a blocked task here; expired IDs are pushed back into the ready lists.

---
 rtl/rtos_dlylist_pkg.sv | 46 ++++
 rtl/rtos_dlylist_locate.sv | 44 ++++
 rtl/rtos_delay_list.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/rtos_dlylist_pkg.sv
// Shared types and helpers for the RTOS delayed-task list.
//   dly_entry_t  : one list slot {valid, id, wake} at the default widths
//   dly_op_e     : the single operation performed in a cycle
//   tick_reached : wrap-safe "tick has reached or passed wake" test
//   rem_gt       : wrap-safe "remaining time of an entry exceeds a delay" test
// The helpers work on 64-bit containers plus a live width, so any TICK_W up to
// 64 can share them.
package rtos_dlylist_pkg;

    localparam int unsigned DLY_ID_W   = 8;
    localparam int unsigned DLY_TICK_W = 32;

    // Slot layout at default widths. The list keeps the same three fields as
    // per-field arrays sized from its own parameters.
    typedef struct packed {
        logic                  valid;
        logic [DLY_ID_W-1:0]   id;
        logic [DLY_TICK_W-1:0] wake;
    } dly_entry_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_DEL,
        OP_POP,
        OP_INS
    } dly_op_e;

    // (tick - wake) mod 2^w has MSB clear once the tick is at or past wake.
    function automatic logic tick_reached(logic [63:0] tick, logic [63:0] wake,
                                          int unsigned w);
        logic [63:0] diff;
        diff = tick - wake;
        return ~diff[w-1];
    endfunction

    // rem = (wake - tick) mod 2^w, compared unsigned against delay.
    function automatic logic rem_gt(logic [63:0] wake, logic [63:0] tick,
                                    logic [63:0] delay, int unsigned w);
        logic [63:0] mask;
        logic [63:0] rem;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        rem  = (wake - tick) & mask;
        return rem > (delay & mask);
    endfunction

endpackage

// File: rtl/rtos_dlylist_locate.sv
// Combinational position finder for the delayed-task list.
//   valid_i/id_i/wake_i : current sorted slot contents (index 0 = head)
//   tick_i, delay_i     : live tick and delay of a prospective insert
//   del_id_i            : ID searched for by a cancel
//   ins_idx_o           : first slot whose remaining time exceeds delay_i
//                         (first free slot if none); equal keys land behind
//   del_idx_o/del_hit_o : lowest valid slot holding del_id_i, and whether found
module rtos_dlylist_locate
    import rtos_dlylist_pkg::*;
#(
    parameter int unsigned MAX_TASKS = 16,
    parameter int unsigned ID_W      = 8,
    parameter int unsigned TICK_W    = 32,
    parameter int unsigned IDX_W     = $clog2(MAX_TASKS + 1)
) (
    input  logic              valid_i [MAX_TASKS],
    input  logic [ID_W-1:0]   id_i    [MAX_TASKS],
    input  logic [TICK_W-1:0] wake_i  [MAX_TASKS],
    input  logic [TICK_W-1:0] tick_i,
    input  logic [TICK_W-1:0] delay_i,
    input  logic [ID_W-1:0]   del_id_i,
    output logic [IDX_W-1:0]  ins_idx_o,
    output logic [IDX_W-1:0]  del_idx_o,
    output logic              del_hit_o
);

    // Scan from the top so the lowest qualifying index wins.
    always_comb begin
        ins_idx_o = IDX_W'(MAX_TASKS);
        del_idx_o = '0;
        del_hit_o = 1'b0;
        for (int i = MAX_TASKS - 1; i >= 0; i--) begin
            if (!valid_i[i] ||
                rem_gt(64'(wake_i[i]), 64'(tick_i), 64'(delay_i), TICK_W)) begin
                ins_idx_o = IDX_W'(i);
            end
            if (valid_i[i] && (id_i[i] == del_id_i)) begin
                del_idx_o = IDX_W'(i);
                del_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rtos_delay_list.sv
// Hardware delayed-task list: sorted (id, wake tick) entries, head at index 0.
// Ports:
//   aclk, aresetn                : clock, async active-low reset
//   tick_in                      : live system tick (wraps)
//   ins_valid/ins_ready/ins_id/ins_delay : insert a task with a relative delay
//   del_valid/del_id             : cancel lowest entry with that ID
//   del_done/del_hit             : cancel result, one cycle later
//   wake_valid/wake_ready/wake_id: expired head handshake
//   head_wake_out                : head wake tick (0 when empty)
//   count_out/empty_out/full_out : occupancy
// Optional (DLYLIST_ERR_EN): err_clr input, sticky err_ovf / err_miss outputs.
// One operation per cycle, priority delete > pop > insert.
module rtos_delay_list
    import rtos_dlylist_pkg::*;
#(
    parameter int unsigned MAX_TASKS = 16,
    parameter int unsigned ID_W      = 8,
    parameter int unsigned TICK_W    = 32,
    localparam int unsigned CNT_W    = $clog2(MAX_TASKS + 1)
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [TICK_W-1:0] tick_in,
    input  logic              ins_valid,
    output logic              ins_ready,
    input  logic [ID_W-1:0]   ins_id,
    input  logic [TICK_W-1:0] ins_delay,
    input  logic              del_valid,
    input  logic [ID_W-1:0]   del_id,
    output logic              del_done,
    output logic              del_hit,
    output logic              wake_valid,
    input  logic              wake_ready,
    output logic [ID_W-1:0]   wake_id,
    output logic [TICK_W-1:0] head_wake_out,
    output logic [CNT_W-1:0]  count_out,
`ifdef DLYLIST_ERR_EN
    input  logic              err_clr,
    output logic              err_ovf,
    output logic              err_miss,
`endif
    output logic              empty_out,
    output logic              full_out
);

    logic              valid_q [MAX_TASKS];
    logic              valid_d [MAX_TASKS];
    logic [ID_W-1:0]   id_q    [MAX_TASKS];
    logic [ID_W-1:0]   id_d    [MAX_TASKS];
    logic [TICK_W-1:0] wake_q  [MAX_TASKS];
    logic [TICK_W-1:0] wake_d  [MAX_TASKS];
    logic [CNT_W-1:0]  count_q, count_d;
    logic              del_done_q, del_done_d;
    logic              del_hit_q, del_hit_d;

    logic [CNT_W-1:0]  ins_idx;
    logic [CNT_W-1:0]  del_idx;
    logic              loc_hit;
    logic              full, empty, pop_fire;
    dly_op_e           op;

    rtos_dlylist_locate #(
        .MAX_TASKS (MAX_TASKS),
        .ID_W      (ID_W),
        .TICK_W    (TICK_W),
        .IDX_W     (CNT_W)
    ) u_locate (
        .valid_i   (valid_q),
        .id_i      (id_q),
        .wake_i    (wake_q),
        .tick_i    (tick_in),
        .delay_i   (ins_delay),
        .del_id_i  (del_id),
        .ins_idx_o (ins_idx),
        .del_idx_o (del_idx),
        .del_hit_o (loc_hit)
    );

    assign full  = (count_q == CNT_W'(MAX_TASKS));
    assign empty = (count_q == '0);

    // A pending cancel masks the wake handshake so the head cannot move under it.
    assign wake_valid = valid_q[0] && !del_valid &&
                        tick_reached(64'(tick_in), 64'(wake_q[0]), TICK_W);
    assign pop_fire   = wake_valid && wake_ready;
    assign ins_ready  = !full && !del_valid && !pop_fire;

    always_comb begin
        op = OP_NONE;
        if (del_valid) begin
            op = OP_DEL;
        end else if (pop_fire) begin
            op = OP_POP;
        end else if (ins_valid && ins_ready) begin
            op = OP_INS;
        end
    end

    always_comb begin
        logic             shift_down;
        logic [CNT_W-1:0] shift_from;

        valid_d    = valid_q;
        id_d       = id_q;
        wake_d     = wake_q;
        count_d    = count_q;
        shift_down = 1'b0;
        shift_from = '0;

        unique case (op)
            OP_DEL: begin
                shift_down = loc_hit;
                shift_from = del_idx;
            end
            OP_POP: begin
                shift_down = 1'b1;
            end
            OP_INS: begin
                for (int i = 1; i < MAX_TASKS; i++) begin
                    if (CNT_W'(i) > ins_idx) begin
                        valid_d[i] = valid_q[i-1];
                        id_d[i]    = id_q[i-1];
                        wake_d[i]  = wake_q[i-1];
                    end
                end
                for (int i = 0; i < MAX_TASKS; i++) begin
                    if (CNT_W'(i) == ins_idx) begin
                        valid_d[i] = 1'b1;
                        id_d[i]    = ins_id;
                        wake_d[i]  = tick_in + ins_delay;
                    end
                end
                count_d = count_q + 1'b1;
            end
            OP_NONE: ;
        endcase

        // Close the gap at shift_from; the top slot always becomes free.
        if (shift_down) begin
            for (int i = 0; i < MAX_TASKS - 1; i++) begin
                if (CNT_W'(i) >= shift_from) begin
                    valid_d[i] = valid_q[i+1];
                    id_d[i]    = id_q[i+1];
                    wake_d[i]  = wake_q[i+1];
                end
            end
            valid_d[MAX_TASKS-1] = 1'b0;
            id_d[MAX_TASKS-1]    = '0;
            wake_d[MAX_TASKS-1]  = '0;
            count_d              = count_q - 1'b1;
        end

        del_done_d = del_valid;
        del_hit_d  = del_valid && loc_hit;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < MAX_TASKS; i++) begin
                valid_q[i] <= 1'b0;
                id_q[i]    <= '0;
                wake_q[i]  <= '0;
            end
            count_q    <= '0;
            del_done_q <= 1'b0;
            del_hit_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            id_q       <= id_d;
            wake_q     <= wake_d;
            count_q    <= count_d;
            del_done_q <= del_done_d;
            del_hit_q  <= del_hit_d;
        end
    end

    assign del_done      = del_done_q;
    assign del_hit       = del_hit_q;
    assign wake_id       = valid_q[0] ? id_q[0] : '0;
    assign head_wake_out = valid_q[0] ? wake_q[0] : '0;
    assign count_out     = count_q;
    assign empty_out     = empty;
    assign full_out      = full;

`ifdef DLYLIST_ERR_EN
    logic err_ovf_q, err_ovf_d;
    logic err_miss_q, err_miss_d;

    // Set beats a simultaneous clear.
    always_comb begin
        err_ovf_d  = (ins_valid && full) || (err_ovf_q && !err_clr);
        err_miss_d = (del_done_q && !del_hit_q) || (err_miss_q && !err_clr);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_ovf_q  <= 1'b0;
            err_miss_q <= 1'b0;
        end else begin
            err_ovf_q  <= err_ovf_d;
            err_miss_q <= err_miss_d;
        end
    end

    assign err_ovf  = err_ovf_q;
    assign err_miss = err_miss_q;
`endif

endmodule
